// File: rtl/ex_stage_if.sv
// EX-stage bus: ID/EX operands and controls, the WB write-back port, MEM-stall/flush
// and the registered EX/MEM outputs.
interface ex_stage_if #(parameter int XLEN = 64);
  logic            stall, flush;
  logic [XLEN-1:0] ex_busA, ex_busB, ex_nextseqpc, ex_immediate;
  logic [4:0]      ex_rd, ex_rf1, ex_rf2;
  logic            ex_alusrc, ex_mem2reg, ex_regwrite, ex_memread, ex_memwrite;
  logic            ex_branch, ex_uncond_branch;
  logic [3:0]      ex_aluctrl;
  logic            ex_rf1_used, ex_rf2_used;
  logic [4:0]      wb_rd;
  logic            wb_regwrite;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] mem_aluresult, mem_storedata, mem_brtarget;
  logic [4:0]      mem_rd;
  logic            mem_mem2reg, mem_regwrite, mem_memread, mem_memwrite, mem_pcsrc;
  logic [31:0]     perf_taken, perf_fwd;

  modport master (
    output stall, flush, ex_busA, ex_busB, ex_nextseqpc, ex_immediate, ex_rd, ex_rf1, ex_rf2,
           ex_alusrc, ex_mem2reg, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
           ex_uncond_branch, ex_aluctrl, ex_rf1_used, ex_rf2_used, wb_rd, wb_regwrite, wb_data,
    input  mem_aluresult, mem_storedata, mem_brtarget, mem_rd, mem_mem2reg, mem_regwrite,
           mem_memread, mem_memwrite, mem_pcsrc, perf_taken, perf_fwd
  );

  modport slave (
    input  stall, flush, ex_busA, ex_busB, ex_nextseqpc, ex_immediate, ex_rd, ex_rf1, ex_rf2,
           ex_alusrc, ex_mem2reg, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
           ex_uncond_branch, ex_aluctrl, ex_rf1_used, ex_rf2_used, wb_rd, wb_regwrite, wb_data,
    output mem_aluresult, mem_storedata, mem_brtarget, mem_rd, mem_mem2reg, mem_regwrite,
           mem_memread, mem_memwrite, mem_pcsrc, perf_taken, perf_fwd
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage + EX/MEM register: operand forwarding, ALU, CBZ/B resolution.
// Optional perf counters (taken branches, forwarded instructions) under EX_PERF_CNT_EN.
module ex_stage #(
  parameter int XLEN     = 64,
  parameter int BR_SHIFT = 2
) (
  input logic      clk,
  input logic      reset,
  ex_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] storedata;
    logic [XLEN-1:0] brtarget;
    logic [4:0]      rd;
    logic            mem2reg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            pcsrc;
  } exmem_t;

  exmem_t          exmem_q, exmem_d;
  logic            fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb, fwd_any;
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res, br_target;
  logic            taken, load;

  // Loads in MEM have no data yet; load-use hazards are stalled upstream.
  always_comb begin
    fwd_a_mem = bus.ex_rf1_used && exmem_q.regwrite && !exmem_q.memread &&
                (exmem_q.rd == bus.ex_rf1) && (bus.ex_rf1 != 5'd31);
    fwd_a_wb  = bus.ex_rf1_used && bus.wb_regwrite &&
                (bus.wb_rd == bus.ex_rf1) && (bus.ex_rf1 != 5'd31);
    fwd_b_mem = bus.ex_rf2_used && exmem_q.regwrite && !exmem_q.memread &&
                (exmem_q.rd == bus.ex_rf2) && (bus.ex_rf2 != 5'd31);
    fwd_b_wb  = bus.ex_rf2_used && bus.wb_regwrite &&
                (bus.wb_rd == bus.ex_rf2) && (bus.ex_rf2 != 5'd31);
    fwd_any   = fwd_a_mem || fwd_a_wb || fwd_b_mem || fwd_b_wb;

    if (fwd_a_mem)     op_a = exmem_q.aluresult;
    else if (fwd_a_wb) op_a = bus.wb_data;
    else               op_a = bus.ex_busA;

    if (fwd_b_mem)     op_b = exmem_q.aluresult;
    else if (fwd_b_wb) op_b = bus.wb_data;
    else               op_b = bus.ex_busB;

    alu_b = bus.ex_alusrc ? bus.ex_immediate : op_b;
  end

  always_comb begin
    case (bus.ex_aluctrl)
      4'b0000: alu_res = op_a & alu_b;
      4'b0001: alu_res = op_a | alu_b;
      4'b0010: alu_res = op_a + alu_b;
      4'b0110: alu_res = op_a - alu_b;
      4'b0111: alu_res = alu_b;
      4'b1100: alu_res = ~(op_a | alu_b);
      default: alu_res = '0;
    endcase
  end

  // Target is computed from the instruction's own PC (nextseqpc - 4).
  always_comb begin
    taken     = bus.ex_uncond_branch || (bus.ex_branch && (alu_res == '0));
    br_target = (bus.ex_nextseqpc - XLEN'(4)) + (bus.ex_immediate << BR_SHIFT);
    load      = !bus.flush && !bus.stall;
  end

  always_comb begin
    exmem_d = exmem_q;
    if (bus.flush) begin
      exmem_d = '0;
    end else if (!bus.stall) begin
      exmem_d.aluresult = alu_res;
      exmem_d.storedata = op_b;
      exmem_d.brtarget  = br_target;
      exmem_d.rd        = bus.ex_rd;
      exmem_d.mem2reg   = bus.ex_mem2reg;
      exmem_d.regwrite  = bus.ex_regwrite;
      exmem_d.memread   = bus.ex_memread;
      exmem_d.memwrite  = bus.ex_memwrite;
      exmem_d.pcsrc     = taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign bus.mem_aluresult = exmem_q.aluresult;
  assign bus.mem_storedata = exmem_q.storedata;
  assign bus.mem_brtarget  = exmem_q.brtarget;
  assign bus.mem_rd        = exmem_q.rd;
  assign bus.mem_mem2reg   = exmem_q.mem2reg;
  assign bus.mem_regwrite  = exmem_q.regwrite;
  assign bus.mem_memread   = exmem_q.memread;
  assign bus.mem_memwrite  = exmem_q.memwrite;
  assign bus.mem_pcsrc     = exmem_q.pcsrc;

`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_taken_q, perf_taken_d, perf_fwd_q, perf_fwd_d;

  always_comb begin
    perf_taken_d = perf_taken_q + 32'(load && taken);
    perf_fwd_d   = perf_fwd_q + 32'(load && fwd_any);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_taken_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_taken_q <= perf_taken_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign bus.perf_taken = perf_taken_q;
  assign bus.perf_fwd   = perf_fwd_q;
`else
  logic unused_perf;
  assign unused_perf    = load ^ fwd_any;
  assign bus.perf_taken = '0;
  assign bus.perf_fwd   = '0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes model predictions, monitor compares each cycle.
module tb_ex_stage;
  localparam int XLEN     = 64;
  localparam int BR_SHIFT = 2;
  typedef logic [XLEN-1:0] word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ex_stage_if #(.XLEN(XLEN)) bus();
  ex_stage #(.XLEN(XLEN), .BR_SHIFT(BR_SHIFT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    word_t alu, sd, bt;
    bit [4:0] rd;
    bit m2r, rw, mr, mw, pc;
    int unsigned pt, pf;
  } exp_t;

  typedef struct {
    word_t a, b, npc, imm, wbd;
    bit [4:0] rd, rf1, rf2, wbrd;
    bit alusrc, m2r, rw, mr, mw, br, ub, u1, u2, wbrw;
    bit [3:0] op;
  } stim_t;

  stim_t s;
  exp_t  m;
  exp_t  q[$];
  exp_t  e;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string n, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.alu = '0; z.sd = '0; z.bt = '0; z.rd = '0;
    z.m2r = 0; z.rw = 0; z.mr = 0; z.mw = 0; z.pc = 0; z.pt = 0; z.pf = 0;
    return z;
  endfunction

  function automatic void clear_stim();
    s.a = '0; s.b = '0; s.npc = '0; s.imm = '0; s.wbd = '0;
    s.rd = '0; s.rf1 = '0; s.rf2 = '0; s.wbrd = '0;
    s.alusrc = 0; s.m2r = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.br = 0; s.ub = 0;
    s.u1 = 0; s.u2 = 0; s.wbrw = 0; s.op = 4'd0;
  endfunction

  // Value an operand actually sees: newest producer wins, X31 and pending loads never do.
  function automatic word_t operand(input bit used, input bit [4:0] rf, input word_t regval,
                                    output bit hit);
    hit = 0;
    if (used && rf != 5'd31 && m.rw && !m.mr && m.rd == rf) begin hit = 1; return m.alu; end
    if (used && rf != 5'd31 && s.wbrw && s.wbrd == rf) begin hit = 1; return s.wbd; end
    return regval;
  endfunction

  function automatic word_t alu(input bit [3:0] op, input word_t a, input word_t b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return b;
      4'd12: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic drive(input bit st, input bit fl);
    bus.stall = st; bus.flush = fl;
    bus.ex_busA = s.a; bus.ex_busB = s.b; bus.ex_nextseqpc = s.npc; bus.ex_immediate = s.imm;
    bus.ex_rd = s.rd; bus.ex_rf1 = s.rf1; bus.ex_rf2 = s.rf2;
    bus.ex_alusrc = s.alusrc; bus.ex_mem2reg = s.m2r; bus.ex_regwrite = s.rw;
    bus.ex_memread = s.mr; bus.ex_memwrite = s.mw; bus.ex_branch = s.br;
    bus.ex_uncond_branch = s.ub; bus.ex_aluctrl = s.op;
    bus.ex_rf1_used = s.u1; bus.ex_rf2_used = s.u2;
    bus.wb_rd = s.wbrd; bus.wb_regwrite = s.wbrw; bus.wb_data = s.wbd;
  endtask

  task automatic step(input bit st, input bit fl);
    bit ha, hb, tk;
    word_t fa, fb, r;
    exp_t n;
    @(negedge clk);
    drive(st, fl);
    if (fl) begin
      n = zero_exp(); n.pt = m.pt; n.pf = m.pf; m = n;
    end else if (!st) begin
      fa = operand(s.u1, s.rf1, s.a, ha);
      fb = operand(s.u2, s.rf2, s.b, hb);
      r  = alu(s.op, fa, s.alusrc ? s.imm : fb);
      tk = s.ub || (s.br && r == 0);
      n.alu = r; n.sd = fb;
      n.bt  = s.npc - 4 + s.imm * word_t'(1 << BR_SHIFT);
      n.rd = s.rd; n.m2r = s.m2r; n.rw = s.rw; n.mr = s.mr; n.mw = s.mw; n.pc = tk;
      n.pt = m.pt; n.pf = m.pf;
`ifdef EX_PERF_CNT_EN
      if (tk) n.pt = m.pt + 1;
      if (ha || hb) n.pf = m.pf + 1;
`endif
      m = n;
    end
    q.push_back(m);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_aluresult", bus.mem_aluresult, e.alu);
        chk("sb_storedata", bus.mem_storedata, e.sd);
        chk("sb_brtarget",  bus.mem_brtarget, e.bt);
        chk("sb_ctrl", word_t'({bus.mem_rd, bus.mem_mem2reg, bus.mem_regwrite, bus.mem_memread,
                                bus.mem_memwrite, bus.mem_pcsrc}),
            word_t'({e.rd, e.m2r, e.rw, e.mr, e.mw, e.pc}));
        chk("sb_perf_taken", word_t'(bus.perf_taken), word_t'(e.pt));
        chk("sb_perf_fwd",   word_t'(bus.perf_fwd), word_t'(e.pf));
      end
    end
  end

  task automatic settle();
    @(posedge clk); #2;
  endtask

  bit [4:0] regs[4] = '{5'd0, 5'd1, 5'd2, 5'd31};
  word_t held;

  initial begin
    clear_stim();
    drive(0, 0);
    m = zero_exp();
    #12;
    chk("reset_state", word_t'({bus.mem_aluresult, bus.mem_regwrite, bus.mem_pcsrc, bus.perf_taken}), '0);
    @(negedge clk); reset = 0;

    // Mid-run async reset
    clear_stim(); s.a = 64'd9; s.b = 64'd9; s.op = 4'd2; s.rd = 5'd4; s.rw = 1; step(0, 0);
    @(posedge clk); #3; reset = 1; #1;
    chk("async_reset_alu", bus.mem_aluresult, '0);
    chk("async_reset_ctl", word_t'({bus.mem_rd, bus.mem_regwrite, bus.mem_pcsrc}), '0);
    m = zero_exp();
    #1 reset = 0;
    clear_stim(); s.a = 64'd5; s.b = 64'd7; s.op = 4'd2; step(0, 0); settle();
    chk("add_5_7", bus.mem_aluresult, 64'd12);

    // Back-to-back dependency through EX/MEM
    clear_stim(); s.a = 64'd4; s.b = 64'd6; s.op = 4'd2; s.rd = 5'd1; s.rw = 1; step(0, 0);
    clear_stim(); s.rf1 = 5'd1; s.u1 = 1; s.rf2 = 5'd2; s.u2 = 1; s.b = 64'd3; s.op = 4'd6;
    step(0, 0); settle();
    chk("fwd_mem_sub", bus.mem_aluresult, 64'd7);

    // MEM beats WB; X31 never forwarded
    clear_stim(); s.a = 64'd20; s.op = 4'd2; s.rd = 5'd2; s.rw = 1; step(0, 0);
    clear_stim(); s.rf2 = 5'd2; s.u2 = 1; s.op = 4'd7; s.wbrd = 5'd2; s.wbrw = 1; s.wbd = 64'd30;
    step(0, 0); settle();
    chk("mem_over_wb", bus.mem_aluresult, 64'd20);
    clear_stim(); s.a = 64'd20; s.op = 4'd2; s.rd = 5'd31; s.rw = 1; step(0, 0);
    clear_stim(); s.rf2 = 5'd31; s.u2 = 1; s.op = 4'd7; s.wbrd = 5'd31; s.wbrw = 1; s.wbd = 64'd30;
    step(0, 0); settle();
    chk("xzr_no_fwd", bus.mem_aluresult, 64'd0);

    // CBZ taken / not taken
    clear_stim(); s.br = 1; s.op = 4'd7; s.npc = 64'h104; s.imm = 64'd3; step(0, 0); settle();
    chk("cbz_taken", word_t'(bus.mem_pcsrc), 64'd1);
    chk("cbz_target", bus.mem_brtarget, 64'h10C);
    s.b = 64'd5; step(0, 0); settle();
    chk("cbz_not_taken", word_t'(bus.mem_pcsrc), 64'd0);

    // Stall holds, stall+flush clears
    held = bus.mem_aluresult;
    for (int i = 0; i < 3; i++) begin
      clear_stim(); s.a = 64'(i + 100); s.b = 64'd1; s.op = 4'd2; s.rw = 1; s.rd = 5'd7;
      step(1, 0);
    end
    settle();
    chk("stall_hold", bus.mem_aluresult, held);
    step(1, 1); settle();
    chk("stall_flush", word_t'({bus.mem_aluresult, bus.mem_regwrite, bus.mem_rd}), '0);

    // Perf counters: 2 taken (one more under stall), 3 WB-forwarded
    @(negedge clk); reset = 1; m = zero_exp(); #1 reset = 0;
    clear_stim(); s.a = 64'd1; s.b = 64'd1; s.op = 4'd2; s.rd = 5'd1; s.rw = 1; step(0, 0);
    clear_stim(); s.ub = 1; step(0, 0);
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      clear_stim(); s.rf1 = 5'd3; s.u1 = 1; s.wbrd = 5'd3; s.wbrw = 1; s.wbd = 64'(i + 1);
      s.op = 4'd2; step(0, 0);
    end
    clear_stim(); s.ub = 1; step(0, 0); settle();
`ifdef EX_PERF_CNT_EN
    chk("perf_taken", word_t'(bus.perf_taken), 64'd2);
    chk("perf_fwd", word_t'(bus.perf_fwd), 64'd3);
`else
    chk("perf_taken_off", word_t'(bus.perf_taken), 64'd0);
    chk("perf_fwd_off", word_t'(bus.perf_fwd), 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit [3:0] ops[8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
      s.a = {$urandom, $urandom}; s.b = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      s.npc = {$urandom, $urandom}; s.imm = {$urandom, $urandom};
      s.wbd = {$urandom, $urandom};
      s.rd = regs[$urandom_range(0, 3)]; s.rf1 = regs[$urandom_range(0, 3)];
      s.rf2 = regs[$urandom_range(0, 3)]; s.wbrd = regs[$urandom_range(0, 3)];
      s.alusrc = 1'($urandom); s.m2r = 1'($urandom); s.rw = 1'($urandom); s.mr = 1'($urandom);
      s.mw = 1'($urandom); s.br = 1'($urandom); s.ub = ($urandom_range(0, 5) == 0);
      s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.wbrw = 1'($urandom);
      s.op = ops[$urandom_range(0, 7)];
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    settle();
    chk("queue_drained", word_t'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
